// File: rtl/servisia_mem_ctrl_if.sv
// Wishbone-side bundle between SERV and the byte-serialising memory controller.
// The master drives the request fields; the slave returns read data and acknowledge.
interface servisia_mem_ctrl_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic [31:0] wb_rdt_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_sel_i,
        output wb_we_i,
        output wb_stb_i,
        input  wb_rdt_o,
        input  wb_ack_o
    );

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_sel_i,
        input  wb_we_i,
        input  wb_stb_i,
        output wb_rdt_o,
        output wb_ack_o
    );
endinterface

// File: rtl/servisia_mem_ctrl.sv
// Splits each 32-bit Wishbone access into four little-endian byte accesses on the 8-bit
// memory port, reassembling read bytes; every transaction acks six cycles after accept.
module servisia_mem_ctrl #(
    parameter int ADDR_W = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    servisia_mem_ctrl_if.slave wb,
    output logic              read_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        wdata_o,
    input  logic [7:0]        rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_LAST,
        ST_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-3:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [31:0]       rdt_q, rdt_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [1:0]        next_idx;
    logic [1:0]        prev_idx;
    logic              unused_adr_bits;

    assign unused_adr_bits = ^{wb.wb_adr_i[31:ADDR_W], wb.wb_adr_i[1:0]};

    // Memory-port outputs are computed one cycle ahead so they leave the block straight from flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        rdt_d    = rdt_q;
        read_d   = 1'b0;
        write_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        next_idx = cnt_q + 2'd1;
        prev_idx = cnt_q - 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (wb.wb_stb_i) begin
                    adr_d   = wb.wb_adr_i[ADDR_W-1:2];
                    dat_d   = wb.wb_dat_i;
                    sel_d   = wb.wb_sel_i;
                    we_d    = wb.wb_we_i;
                    cnt_d   = 2'd0;
                    state_d = ST_ACCESS;
                    read_d  = ~wb.wb_we_i;
                    write_d = wb.wb_we_i & wb.wb_sel_i[0];
                    addr_d  = {wb.wb_adr_i[ADDR_W-1:2], 2'b00};
                    wdata_d = wb.wb_dat_i[7:0];
                end
            end

            ST_ACCESS: begin
                // Memory read data lags read_o by one cycle, so this cycle returns the previous byte.
                if (!we_q && cnt_q != 2'd0) begin
                    rdt_d[{prev_idx, 3'b000} +: 8] = rdata_i;
                end
                if (cnt_q == 2'd3) begin
                    state_d = ST_LAST;
                end else begin
                    cnt_d   = next_idx;
                    read_d  = ~we_q;
                    write_d = we_q & sel_q[next_idx];
                    addr_d  = {adr_q, next_idx};
                    wdata_d = dat_q[{next_idx, 3'b000} +: 8];
                end
            end

            ST_LAST: begin
                if (!we_q) begin
                    rdt_d[31:24] = rdata_i;
                end
                state_d = ST_ACK;
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            adr_q   <= '0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            rdt_q   <= 32'd0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdt_q   <= rdt_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign read_o      = read_q;
    assign write_o     = write_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign wb.wb_rdt_o = rdt_q;
    assign wb.wb_ack_o = (state_q == ST_ACK);

endmodule

// File: tb/tb_servisia_mem_ctrl.sv
// Directed and randomized bench for servisia_mem_ctrl, with a byte-wide memory model on the
// downstream port and a word-level reference memory kept by the bench.
module tb_servisia_mem_ctrl;
    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              read_o;
    logic              write_o;
    logic [ADDR_W-1:0] addr_o;
    logic [7:0]        wdata_o;
    logic [7:0]        rdata_i;

    logic              preloadEn;
    logic [ADDR_W-1:0] preloadAddr;
    logic [7:0]        preloadData;

    bit [7:0]          memArr [0:(1<<ADDR_W)-1];
    bit [7:0]          refMem [bit [ADDR_W-1:0]];
    logic [31:0]       expRdt;

    int checksTotal  = 0;
    int checksPassed = 0;

    servisia_mem_ctrl_if bus ();

    servisia_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .wb      (bus),
        .read_o  (read_o),
        .write_o (write_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .rdata_i (rdata_i)
    );

    always #5 clk = ~clk;

    // Downstream byte memory: registered read data, plus a backdoor for preloading.
    always @(posedge clk) begin
        if (preloadEn) memArr[preloadAddr] <= preloadData;
        if (write_o)   memArr[addr_o] <= wdata_o;
        if (read_o)    rdata_i <= memArr[addr_o];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    function automatic logic [31:0] refWord(input logic [31:0] adr);
        logic [31:0]       word;
        logic [ADDR_W-1:0] a;
        word = 32'd0;
        for (int k = 0; k < 4; k++) begin
            a = {adr[ADDR_W-1:2], 2'(k)};
            word[8*k +: 8] = refMem.exists(a) ? refMem[a] : 8'h00;
        end
        return word;
    endfunction

    task automatic preloadByte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        preloadEn   = 1'b1;
        preloadAddr = a;
        preloadData = d;
        @(posedge clk); #1;
        preloadEn = 1'b0;
        refMem[a] = d;
    endtask

    // Called during an IDLE cycle; returns in the following IDLE cycle.
    task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                                 input logic we, input bit keepStb, input bit midChange);
        logic [ADDR_W-1:0] expAddr;
        logic [31:0]       expWord;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_stb_i = 1'b1;
        expWord = refWord(adr);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1 && !keepStb) bus.wb_stb_i = 1'b0;
            if (cyc == 2 && midChange) begin
                bus.wb_adr_i = $urandom;
                bus.wb_dat_i = $urandom;
                bus.wb_sel_i = 4'($urandom);
                bus.wb_we_i  = ~we;
            end
            checkOutput("rw_exclusive", 32'(read_o & write_o), 32'd0);
            if (cyc <= 4) begin
                expAddr = {adr[ADDR_W-1:2], 2'(cyc - 1)};
                checkOutput("addr_o", 32'(addr_o), 32'(expAddr));
                checkOutput("read_o", 32'(read_o), 32'(!we));
                checkOutput("write_o", 32'(write_o), 32'(we & sel[cyc-1]));
                if (we) checkOutput("wdata_o", 32'(wdata_o), 32'(dat[8*(cyc-1) +: 8]));
                checkOutput("ack_early", 32'(bus.wb_ack_o), 32'd0);
            end else if (cyc == 5) begin
                checkOutput("last_read_o", 32'(read_o), 32'd0);
                checkOutput("last_write_o", 32'(write_o), 32'd0);
                checkOutput("ack_early", 32'(bus.wb_ack_o), 32'd0);
            end else begin
                checkOutput("ack_cycle6", 32'(bus.wb_ack_o), 32'd1);
                if (!we) expRdt = expWord;
                checkOutput("wb_rdt_o", bus.wb_rdt_o, expRdt);
            end
        end
        if (we) begin
            for (int k = 0; k < 4; k++)
                if (sel[k]) refMem[{adr[ADDR_W-1:2], 2'(k)}] = dat[8*k +: 8];
        end
        @(posedge clk); #1;
        checkOutput("ack_one_cycle", 32'(bus.wb_ack_o), 32'd0);
    endtask

    initial begin
        logic [31:0] rAdr;
        logic [31:0] rDat;

        rst          = 1'b1;
        preloadEn    = 1'b0;
        preloadAddr  = '0;
        preloadData  = 8'd0;
        bus.wb_adr_i = 32'd0;
        bus.wb_dat_i = 32'd0;
        bus.wb_sel_i = 4'd0;
        bus.wb_we_i  = 1'b0;
        bus.wb_stb_i = 1'b0;
        expRdt       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        checkOutput("rst_rdt", bus.wb_rdt_o, 32'd0);
        checkOutput("rst_read", 32'(read_o), 32'd0);
        checkOutput("rst_write", 32'(write_o), 32'd0);
        checkOutput("rst_addr", 32'(addr_o), 32'd0);
        checkOutput("rst_wdata", 32'(wdata_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] word read with preloaded bytes");
        preloadByte(20'h10, 8'h10);
        preloadByte(20'h11, 8'h32);
        preloadByte(20'h12, 8'h54);
        preloadByte(20'h13, 8'h76);
        applyStimulus(32'h0000_0010, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_word", bus.wb_rdt_o, 32'h7654_3210);

        $display("[TB] full and partial writes with readback");
        applyStimulus(32'h0008_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h0008_0000, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_readback", bus.wb_rdt_o, 32'hDEAD_BEEF);
        applyStimulus(32'h0008_0000, 32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_rdt_held", bus.wb_rdt_o, 32'hDEAD_BEEF);
        applyStimulus(32'h0008_0000, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3_readback", bus.wb_rdt_o, 32'hDEBB_BEDD);

        $display("[TB] reset in the middle of a write");
        applyStimulus(32'h0000_0040, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 1'b0);
        bus.wb_adr_i = 32'h0000_0040;
        bus.wb_dat_i = 32'hA5B6_C7D8;
        bus.wb_sel_i = 4'hF;
        bus.wb_we_i  = 1'b1;
        bus.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        bus.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rstmid_write", 32'(write_o), 32'd0);
        checkOutput("rstmid_read", 32'(read_o), 32'd0);
        checkOutput("rstmid_addr", 32'(addr_o), 32'd0);
        checkOutput("rstmid_wdata", 32'(wdata_o), 32'd0);
        checkOutput("rstmid_rdt", bus.wb_rdt_o, 32'd0);
        checkOutput("rstmid_ack", 32'(bus.wb_ack_o), 32'd0);
        rst = 1'b0;
        expRdt = 32'd0;
        for (int k = 0; k < 3; k++) refMem[20'h40 + 20'(k)] = 8'(32'hA5B6_C7D8 >> (8*k));
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checkOutput("rstmid_no_write", 32'(write_o), 32'd0);
            checkOutput("rstmid_no_ack", 32'(bus.wb_ack_o), 32'd0);
        end
        applyStimulus(32'h0000_0040, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("rstmid_readback", bus.wb_rdt_o, 32'h11B6_C7D8);

        $display("[TB] back-to-back with address change mid-transaction");
        applyStimulus(32'h0000_0080, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0000_0080, 32'd0, 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_word", bus.wb_rdt_o, 32'h0BAD_F00D);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            rAdr = ($urandom & 32'hFFF0_0003) | (32'h0000_0400 + 32'($urandom_range(0, 7)) * 4);
            rDat = $urandom;
            applyStimulus(rAdr, rDat, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          1'b0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
